// File: rtl/cache_miss_fsm.sv
// Miss-service controller for a 2-way set-associative cache.
// Takes the chosen victim way, writes it back if it is valid and dirty,
// invalidates it, refills it one word per memory handshake, then commits
// the new tag as valid and clean.
module cache_miss_fsm #(
  parameter int INDEX_W = 6,
  parameter int WORDS   = 8,
  parameter int TAG_W   = 21,
  localparam int WORD_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss,
  input  logic [31:0]       miss_addr,
  input  logic              victim,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic              arr_rd_way,
  output logic [WORD_W-1:0] arr_rd_idx,
  input  logic [31:0]       arr_rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              fill_we,
  output logic              fill_way,
  output logic [WORD_W-1:0] fill_idx,
  output logic [31:0]       fill_data,
  output logic              tag_we,
  output logic [TAG_W-1:0]  tag_out,
  output logic              tag_valid,
  output logic              busy,
  output logic              done
);

  localparam int LINE_W = TAG_W + INDEX_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB     = 3'd1,
    INV    = 3'd2,
    FILL   = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;     // {miss tag, set index}
  logic                victim_q, victim_d;
  logic [TAG_W-1:0]    vtag_q, vtag_d;

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    miss_tag;
  logic                last_word;
  logic                unused_addr_bits;

  assign index     = line_q[INDEX_W-1:0];
  assign miss_tag  = line_q[LINE_W-1:INDEX_W];
  assign last_word = (cnt_q == WORD_W'(WORDS - 1));
  // Byte offset within the word never matters: all transfers are word aligned.
  assign unused_addr_bits = ^miss_addr[WORD_W+1:0];

  // busy follows the state register, so it rises the cycle after acceptance.
  assign busy = (state_q != IDLE);

  // State, word counter and latched request; reset aborts any service.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      victim_q <= 1'b0;
      vtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      victim_q <= victim_d;
      vtag_q   <= vtag_d;
    end
  end

  // Next-state and output decode; every output is zero unless a state drives it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    victim_d   = victim_q;
    vtag_d     = vtag_q;
    arr_rd_way = 1'b0;
    arr_rd_idx = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_we    = 1'b0;
    fill_way   = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    tag_we     = 1'b0;
    tag_out    = '0;
    tag_valid  = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss) begin
          line_d   = miss_addr[31:WORD_W+2];
          victim_d = victim;
          vtag_d   = victim_tag;
          cnt_d    = '0;
          // Only a line that is both valid and dirty holds data worth saving.
          state_d  = (victim_valid && victim_dirty) ? WB : INV;
        end
      end

      WB: begin
        // Address and data derive only from registered state, so they stay
        // stable for as long as memory takes to acknowledge.
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {vtag_q, index, cnt_q, 2'b00};
        arr_rd_way = victim_q;
        arr_rd_idx = cnt_q;
        mem_wdata  = arr_rd_data;
        if (mem_ack) begin
          if (last_word) begin
            cnt_d   = '0;
            state_d = INV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      INV: begin
        // Invalidate first so a partially refilled line never looks valid.
        tag_we    = 1'b1;
        tag_valid = 1'b0;
        tag_out   = miss_tag;
        fill_way  = victim_q;
        state_d   = FILL;
      end

      FILL: begin
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = {line_q, cnt_q, 2'b00};
        if (mem_ack) begin
          fill_we   = 1'b1;
          fill_way  = victim_q;
          fill_idx  = cnt_q;
          fill_data = mem_rdata;
          if (last_word) begin
            cnt_d   = '0;
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      COMMIT: begin
        tag_we    = 1'b1;
        tag_valid = 1'b1;
        tag_out   = miss_tag;
        fill_way  = victim_q;
        done      = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_miss_fsm.sv
// Directed bench for cache_miss_fsm: a table of miss scenarios run through a
// memory/array model with per-cycle checks, plus reset-abort and stray-ack
// sequences.
module tb_cache_miss_fsm;

  localparam int INDEX_W = 6;
  localparam int WORDS   = 8;
  localparam int TAG_W   = 21;
  localparam int WORD_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              miss;
  logic [31:0]       miss_addr;
  logic              victim;
  logic              victim_valid;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic              arr_rd_way;
  logic [WORD_W-1:0] arr_rd_idx;
  logic [31:0]       arr_rd_data;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              fill_we;
  logic              fill_way;
  logic [WORD_W-1:0] fill_idx;
  logic [31:0]       fill_data;
  logic              tag_we;
  logic [TAG_W-1:0]  tag_out;
  logic              tag_valid;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  cache_miss_fsm #(.INDEX_W(INDEX_W), .WORDS(WORDS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr),
    .victim(victim), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .arr_rd_way(arr_rd_way), .arr_rd_idx(arr_rd_idx),
    .arr_rd_data(arr_rd_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .fill_we(fill_we), .fill_way(fill_way),
    .fill_idx(fill_idx), .fill_data(fill_data), .tag_we(tag_we),
    .tag_out(tag_out), .tag_valid(tag_valid), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0]      addr;
    logic             vic;
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] vtag;
    int               period;     // one ack every 'period' request cycles
    bit               toggle;     // wiggle request inputs while busy
    int               exp_done;   // cycle of done, counted from acceptance
    int               exp_writes;
  } vec_t;

  vec_t vecs[6];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] arr_model(input logic way, input logic [WORD_W-1:0] idx);
    return 32'hC0DE_0000 ^ (way ? 32'h0000_1000 : 32'h0) ^ {29'd0, idx};
  endfunction

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {mem_req, mem_we, mem_addr, fill_we, fill_way, fill_idx,
                         tag_we, tag_valid, busy, done, arr_rd_way, arr_rd_idx}, 64'd0);
    chk({name, "_dat"}, {mem_wdata, tag_out}, 64'd0);
    chk({name, "_fill"}, fill_data, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int wcnt = 0;
    int rcnt = 0;
    int invs = 0;
    int commits = 0;
    int done_c = 0;
    int pc = 0;
    logic ackv;
    logic [31:0] ea;
    @(negedge clk);
    miss = 1'b1; miss_addr = v.addr; victim = v.vic; victim_valid = v.valid;
    victim_dirty = v.dirty; victim_tag = v.vtag; mem_ack = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 300 && done_c == 0; c++) begin
      @(negedge clk);
      ackv = mem_req && ((pc % v.period) == v.period - 1);
      if (mem_req) pc++;
      mem_ack     = ackv;
      mem_rdata   = mem_model(mem_addr);
      arr_rd_data = arr_model(arr_rd_way, arr_rd_idx);
      #1;
      chk("busy", busy, 1);
      if (mem_req && mem_we) begin
        ea = {v.vtag, v.addr[10:5], wcnt[2:0], 2'b00};
        chk("wb_addr", mem_addr, ea);
        chk("wb_data", mem_wdata, arr_model(v.vic, wcnt[2:0]));
        chk("wb_nofill", {fill_we, tag_we}, 0);
        if (ackv) wcnt++;
      end else if (mem_req) begin
        ea = {v.addr[31:5], rcnt[2:0], 2'b00};
        chk("rd_addr", mem_addr, ea);
        if (ackv) begin
          chk("fill", {fill_we, fill_way, fill_idx, fill_data},
              {1'b1, v.vic, rcnt[2:0], mem_model(ea)});
          rcnt++;
        end else begin
          chk("fill_hold", fill_we, 0);
        end
      end
      if (tag_we && !tag_valid) begin
        invs++;
        chk("inv", {tag_out, fill_way, mem_req, done}, {v.addr[31:11], v.vic, 2'b00});
        chk("inv_after_wb", wcnt, v.exp_writes);
      end
      if (tag_we && tag_valid) begin
        commits++;
        chk("commit", {tag_out, fill_way, mem_req, done}, {v.addr[31:11], v.vic, 2'b01});
        chk("commit_after_fill", rcnt, WORDS);
        done_c = c;
      end else if (done) begin
        done_c = c;
      end
      if (v.toggle) begin
        miss         = (done_c == 0) && c[0];
        miss_addr    = $urandom;
        victim       = ~victim;
        victim_tag   = TAG_W'($urandom);
        victim_dirty = 1'b1;
        victim_valid = 1'b1;
      end else begin
        miss = 1'b0;
      end
    end
    mem_ack = 1'b0;
    miss    = 1'b0;
    chk("done_cycle", done_c, v.exp_done);
    chk("wb_words", wcnt, v.exp_writes);
    chk("fill_words", rcnt, WORDS);
    chk("inv_count", invs, 1);
    chk("commit_count", commits, 1);
    @(negedge clk);
    #1;
    chk("idle_after", {busy, done, mem_req, tag_we}, 0);
    $display("txn %0d: addr=%h victim=%0d dirty_wb=%0d period=%0d done_cycle=%0d",
             id, v.addr, v.vic, wcnt, v.period, done_c);
  endtask

  initial begin
    int fills;
    vecs[0] = '{32'h0000_1240, 1'b1, 1'b1, 1'b0, 21'h1F0F0, 1, 1'b0, 10, 0};
    vecs[1] = '{32'h0000_1240, 1'b0, 1'b1, 1'b1, 21'h00ABC, 1, 1'b0, 18, 8};
    vecs[2] = '{32'h0000_1240, 1'b1, 1'b0, 1'b1, 21'h0DEAD, 1, 1'b0, 10, 0};
    vecs[3] = '{32'h0003_7F80, 1'b0, 1'b1, 1'b0, 21'h00001, 3, 1'b0, 26, 0};
    vecs[4] = '{32'hFFFF_FFE0, 1'b1, 1'b1, 1'b1, 21'h1ABCD, 3, 1'b0, 50, 8};
    vecs[5] = '{32'h8000_0100, 1'b1, 1'b1, 1'b1, 21'h00123, 1, 1'b1, 18, 8};

    rst = 1'b1; miss = 1'b0; miss_addr = '0; victim = 1'b0; victim_valid = 1'b0;
    victim_dirty = 1'b0; victim_tag = '0; arr_rd_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset in the middle of a refill: abort, then ignore stray acks.
    @(negedge clk);
    miss = 1'b1; miss_addr = 32'h0000_2A60; victim = 1'b0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    @(posedge clk);
    fills = 0;
    for (int c = 0; c < 40 && fills < 4; c++) begin
      @(negedge clk);
      miss      = 1'b0;
      mem_ack   = mem_req;
      mem_rdata = mem_model(mem_addr);
      #1;
      if (mem_req && !mem_we && mem_ack) fills++;
    end
    chk("rst_fills_seen", fills, 4);
    @(negedge clk);
    mem_ack = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    #1;
    check_zero("rst_mid_fill");
    rst     = 1'b0;
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("stray_ack_idle", {busy, mem_req, fill_we, tag_we, done}, 0);
    end
    mem_ack = 1'b0;
    $display("txn rst: reset after %0d fill acks, controller idle", fills);

    run_vec(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_miss_fsm.md
Name: cache_miss_fsm

Overview:
- Miss-service controller for the 2-way set-associative cache. It sits directly downstream of victim-way selection.
- On a miss it takes the chosen victim way, writes that line back to memory if it is dirty, then refills it word by word from memory.
- It finishes by committing the new tag with valid=1 and dirty=0.
- The pipeline stalls on `busy` for the whole service.

Parameters:
- INDEX_W, 6, set index width
- WORDS, 8, 32-bit words per line (power of two); WORD_W = log2(WORDS)
- TAG_W, 21, tag width; TAG_W + INDEX_W + WORD_W + 2 = 32

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- miss  in  1  miss request from compare stage (level)
- miss_addr  in  32  missing byte address
- victim  in  1  chosen way from victim decision
- victim_valid  in  1  valid bit of chosen way
- victim_dirty  in  1  dirty bit of chosen way
- victim_tag  in  TAG_W  tag of chosen way
- arr_rd_way  out  1  data-array read way
- arr_rd_idx  out  WORD_W  data-array read word index (set from latched address)
- arr_rd_data  in  32  combinational read data, same cycle
- mem_req  out  1  memory request, one word per handshake
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  word transfer complete
- fill_we  out  1  data-array word write enable
- fill_way  out  1  way written
- fill_idx  out  WORD_W  word written
- fill_data  out  32  word written
- tag_we  out  1  tag/valid/dirty write enable for fill_way
- tag_out  out  TAG_W  tag written
- tag_valid  out  1  valid bit written (dirty always written 0)
- busy  out  1  controller not idle
- done  out  1  one-cycle pulse, line committed

Behaviour:
- **Reset.** State=IDLE, cnt=0, latched fields=0. All outputs 0. Reset mid-operation aborts immediately; no further writes occur.
- **States:** IDLE, WB, INV, FILL, COMMIT.
- **busy** = (state != IDLE). It is registered from the state, so it is high the cycle after miss is accepted.
- **IDLE.** When miss=1:
  - Latch addr[31:WORD_W+2], victim, victim_tag and need_wb = victim_valid & victim_dirty.
  - If need_wb, go to WB; else go to INV.
  - Inputs in other states are ignored. A miss held high across done is re-accepted next cycle only if the compare stage still asserts it.
- **WB.**
  - mem_req=1, mem_we=1.
  - mem_addr = {victim_tag, index, cnt, 2'b00}; mem_wdata = arr_rd_data.
  - arr_rd_way = victim; arr_rd_idx = cnt.
  - Addr and data are held stable until mem_ack.
  - On mem_ack: cnt++. If cnt==WORDS-1, set cnt=0 and go to INV.
- **INV** (1 cycle).
  - tag_we=1, tag_valid=0, tag_out=latched miss tag, fill_way=victim.
  - Invalidates the way so a partial fill is never seen as valid. Then go to FILL.
- **FILL.**
  - mem_req=1, mem_we=0, mem_addr = {miss tag, index, cnt, 2'b00}.
  - On mem_ack, in the same cycle: fill_we=1, fill_way=victim, fill_idx=cnt, fill_data=mem_rdata; cnt++.
  - If cnt==WORDS-1, set cnt=0 and go to COMMIT.
- **COMMIT** (1 cycle).
  - tag_we=1, tag_valid=1, tag_out=miss tag, done=1.
  - Then go to IDLE.
- **mem_ack handling.** mem_ack while mem_req=0 is ignored. mem_req drops the cycle after the last ack of each phase.
- **Latency.** Clean miss: 1 (INV) + WORDS acks + 1 (COMMIT) cycles after acceptance. Dirty miss adds WORDS acks.
- **cnt** wraps only via explicit clear; it never exceeds WORDS-1.

Test Plan:
- **Clean miss.** miss=1, miss_addr=0x0000_1240, victim=1, valid=1, dirty=0, mem_ack=1 every cycle.
  - Expect: INV tag_we with valid=0.
  - Expect: 8 reads at 0x1240..0x125C; fill_we on idx 0..7 to way 1.
  - Expect: COMMIT tag_we with valid=1; done 10 cycles after acceptance; no mem_we.
- **Dirty miss.** victim=0, dirty=1, victim_tag=0x00ABC, same addr.
  - Expect: 8 writes at {0x00ABC, index, 0..7, 00} with arr_rd_data, then the clean sequence.
  - Expect: done after 18 cycles.
- **Invalid victim with dirty=1.** Expect: writeback skipped, sequence identical to the clean miss.
- **Slow memory.** mem_ack every 3rd cycle.
  - Expect: mem_addr/mem_wdata stable between acks.
  - Expect: exactly 8 fill_we pulses; busy high throughout.
- **Reset mid-FILL.** Assert rst after 4th ack.
  - Expect: all outputs 0 next cycle; busy=0; no COMMIT tag write.
  - Expect: a subsequent miss is serviced normally.
- **Miss during busy.** Toggle miss and change miss_addr while in WB.
  - Expect: no effect; addresses still come from the latched request.
  - Expect: stray mem_ack in IDLE causes no writes.
